// File: rtl/uart_tx_arb.sv
// Round-robin sequencer sharing one UART transmitter among N_REQ byte sources.
// Define UART_TX_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins).
module uart_tx_arb #(
   parameter int N_REQ          = 4,
   parameter int DATA_W         = 8,
   parameter int GAP_CYCLES     = 0,
   parameter int TIMEOUT_CYCLES = 1048576
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [N_REQ-1:0]          req,
   input  logic [N_REQ*DATA_W-1:0]   req_data,
   output logic [N_REQ-1:0]          ack,
   output logic [N_REQ-1:0]          done,
   output logic                      tx_start,
   output logic [DATA_W-1:0]         tx_din,
   input  logic                      tx_done_tick,
   output logic                      busy,
   output logic [$clog2(N_REQ)-1:0]  grant_id,
   output logic                      err_timeout
);

   localparam int IW   = $clog2(N_REQ);
   localparam int MAXC = (TIMEOUT_CYCLES > GAP_CYCLES) ? TIMEOUT_CYCLES
                                                       : GAP_CYCLES;
   localparam int TW   = $clog2(MAXC + 1);
   localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYCLES - 1);
   localparam logic [TW-1:0] GAP_LAST =
      TW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
   localparam logic [IW:0]   NQ       = (IW+1)'(N_REQ);

   typedef enum logic [1:0] {
      S_IDLE,
      S_START,
      S_WAIT,
      S_GAP
   } state_t;

   state_t              state_q, state_d;
   logic [IW-1:0]       ptr_q, ptr_d;
   logic [TW-1:0]       timer_q, timer_d;
   logic [N_REQ-1:0]    ack_q, ack_d;
   logic [N_REQ-1:0]    done_q, done_d;
   logic                start_q, start_d;
   logic [DATA_W-1:0]   din_q, din_d;
   logic                busy_q, busy_d;
   logic [IW-1:0]       gid_q, gid_d;
   logic                err_q, err_d;

   logic [2*N_REQ-1:0]  dbl;
   logic [N_REQ-1:0]    rot;
   logic [IW-1:0]       off;
   logic [IW:0]         sum;
   logic [IW-1:0]       win;
   logic [N_REQ-1:0]    win_oh;
   logic [N_REQ-1:0]    gnt_oh;
   logic [DATA_W-1:0]   win_byte;

   // Rotate req so bit 0 is the pointer slot, then map the offset back.
   always_comb begin
      dbl = {req, req} >> ptr_q;
      rot = dbl[N_REQ-1:0];
      off = '0;
      for (int k = N_REQ - 1; k >= 0; k--) begin
         if (rot[k]) off = IW'(k);
      end
      sum = {1'b0, ptr_q} + {1'b0, off};
      win = (sum >= NQ) ? IW'(sum - NQ) : sum[IW-1:0];
   end

   always_comb begin
      win_oh   = '0;
      gnt_oh   = '0;
      win_byte = '0;
      for (int i = 0; i < N_REQ; i++) begin
         win_oh[i] = (win == IW'(i));
         gnt_oh[i] = (gid_q == IW'(i));
         if (win == IW'(i)) win_byte = req_data[i*DATA_W +: DATA_W];
      end
   end

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      timer_d = timer_q;
      ack_d   = '0;
      done_d  = '0;
      start_d = 1'b0;
      din_d   = din_q;
      gid_d   = gid_q;
      err_d   = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (|req) begin
               din_d   = win_byte;
               gid_d   = win;
               ack_d   = win_oh;
`ifndef UART_TX_ARB_FIXED_PRIO_EN
               ptr_d   = (win == IW'(N_REQ - 1)) ? '0 : win + IW'(1);
`endif
               state_d = S_START;
            end
         end
         S_START: begin
            start_d = 1'b1;
            timer_d = '0;
            state_d = S_WAIT;
         end
         S_WAIT: begin
            if (tx_done_tick || timer_q == TO_LAST) begin
               done_d  = tx_done_tick ? gnt_oh : '0;
               err_d   = !tx_done_tick;
               timer_d = '0;
               state_d = (GAP_CYCLES > 0) ? S_GAP : S_IDLE;
            end else begin
               timer_d = timer_q + TW'(1);
            end
         end
         S_GAP: begin
            if (timer_q == GAP_LAST) begin
               state_d = S_IDLE;
            end else begin
               timer_d = timer_q + TW'(1);
            end
         end
         default: state_d = S_IDLE;
      endcase
      busy_d = (state_d != S_IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         ptr_q   <= '0;
         timer_q <= '0;
         ack_q   <= '0;
         done_q  <= '0;
         start_q <= 1'b0;
         din_q   <= '0;
         busy_q  <= 1'b0;
         gid_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         timer_q <= timer_d;
         ack_q   <= ack_d;
         done_q  <= done_d;
         start_q <= start_d;
         din_q   <= din_d;
         busy_q  <= busy_d;
         gid_q   <= gid_d;
         err_q   <= err_d;
      end
   end

   assign ack         = ack_q;
   assign done        = done_q;
   assign tx_start    = start_q;
   assign tx_din      = din_q;
   assign busy        = busy_q;
   assign grant_id    = gid_q;
   assign err_timeout = err_q;

endmodule
